mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the EX/MEM register. Consumes the EX/MEM outputs (control, branch target, ALU zero and result, store data, destination register), performs the data-memory read or write, resolves the branch decision for the fetch stage, and registers the results into the MEM/WB pipeline register for write-back.

## Interface
Parameters:
- `MEM_WORDS`, default 256: data-memory depth in 32-bit words; must be a power of two.
- `ADDR_W`, default 8: log2(`MEM_WORDS`), the word-index width.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wb_ctlout`  in  2  WB control from EX/MEM: [1]=RegWrite, [0]=MemtoReg.
- `m_ctlout`  in  3  M control: [2]=Branch, [1]=MemRead, [0]=MemWrite.
- `add_result`  in  32  branch target address.
- `zero`  in  1  ALU zero flag.
- `alu_result`  in  32  effective address, or the ALU value for R-type instructions.
- `rdata2out`  in  32  store data.
- `five_bit_muxout`  in  5  destination register number.
- `pcsrc`  out  1  branch taken: select `branch_target` at the PC mux.
- `branch_target`  out  32  equal to `add_result` (pass-through).
- `memwb_wb`  out  2  registered WB control.
- `memwb_read_data`  out  32  registered load data.
- `memwb_alu_result`  out  32  registered `alu_result`.
- `memwb_write_reg`  out  5  registered destination register.

## Operation
- Word index = `alu_result[ADDR_W+1:2]`.
  - Bits [1:0] are ignored; there are no misalignment faults.
  - Bits above `ADDR_W+1` are ignored, so addresses wrap modulo `MEM_WORDS`×4 bytes.
- Store: when `m_ctlout[0]`=1 and `rst`=0, `mem[index]` ← `rdata2out` at the rising edge.
  - A store is suppressed while `rst`=1.
- Load: when `m_ctlout[1]`=1, `memwb_read_data` ← `mem[index]` at the rising edge.
  - When `m_ctlout[1]`=0, `memwb_read_data` ← 0.
- Read and write in the same cycle to the same index: the write lands and the load returns the OLD word (read-before-write).
- `pcsrc` = `m_ctlout[2]` & `zero` & ~`rst`. It is combinational, with no register.
- `branch_target` = `add_result`. It is combinational.
- MEM/WB register: `memwb_wb`, `memwb_alu_result` and `memwb_write_reg` capture their inputs every cycle (no stall or enable).
- Reset:
  - All `memwb_*` outputs go to 0 on the first rising edge with `rst`=1 and hold 0 while `rst` stays high.
  - Memory contents are NOT cleared by `rst`. Every word is 0 at time zero.
- Reset mid-operation: a store presented in the same cycle as `rst` is lost. Earlier stores persist.
- The block does not decode X/Z on control inputs. The bench drives known values.

## Timing
- Store-to-memory latency: 1 edge.
- A load issued in cycle N sees a store from cycle N−1 or earlier. It does not see a store from cycle N.
- Load latency: the value appears on `memwb_read_data` 1 edge after the input cycle, aligned with the `memwb_wb`, `memwb_alu_result` and `memwb_write_reg` from the same instruction.
- `pcsrc` and `branch_target`: 0 cycles, valid in the same cycle as the EX/MEM outputs.
- Throughput: one instruction per cycle, no back-pressure.

## Structure
- Shared package/header `mips_pkg`. It holds:
  - bit-index constants `WB_REGWRITE`=1, `WB_MEMTOREG`=0, `M_BRANCH`=2, `M_MEMREAD`=1, `M_MEMWRITE`=0;
  - control-field widths 2 and 3;
  - the word width of 32.
- One sub-module, `data_memory`:
  - `MEM_WORDS`×32 array with synchronous write and a read port;
  - inputs `clk`, `we`, `re`, `addr[ADDR_W-1:0]`, `wdata`; output `rdata`.
- `mem_stage` holds the branch logic and the MEM/WB register.

## Test plan
- Reset: drive all inputs nonzero with `rst`=1 for 2 cycles.
  - Required: all `memwb_*` = 0 and `pcsrc`=0.
  - Required: memory word 0 still reads 0 after release.
- Store then load: store `rdata2out`=0xDEADBEEF at `alu_result`=0x10, then load 0x10 on the next cycle.
  - Required: `memwb_read_data`=0xDEADBEEF one edge later, with `memwb_wb` and `memwb_write_reg` matching the load's inputs.
- Same-cycle read/write: index 4 holds 0x11111111; drive MemRead=MemWrite=1 with data 0x22222222.
  - Required: `memwb_read_data`=0x11111111.
  - Required: a following load returns 0x22222222.
- Wrap and low bits: store 0xA5A5A5A5 at `alu_result`=0x00000403 with `MEM_WORDS`=256.
  - Required: a load at 0x00000000 returns 0xA5A5A5A5.
- Branch: Branch=1 with `zero`=1 → `pcsrc`=1 and `branch_target`=`add_result`=0x00400020 in the same cycle.
  - Required: `zero`=0 gives `pcsrc`=0, and `rst`=1 forces `pcsrc`=0.
- Reset mid-store: store 0x5 to index 7 in the same cycle as `rst`=1.
  - Required: a later load of index 7 returns 0, not 0x5.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline stages.
package mips_pkg;

    // Bit positions inside the WB control field
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // Bit positions inside the M control field
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

    // Field widths
    localparam int WB_W   = 2;
    localparam int M_W    = 3;
    localparam int WORD_W = 32;

    typedef logic [WB_W-1:0]   wb_ctl_t;
    typedef logic [M_W-1:0]    m_ctl_t;
    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read.
// The read port returns zero when not enabled, so the caller can register it
// directly. Because the read is combinational and the write lands on the edge,
// a same-index read and write in one cycle returns the old word.
module data_memory
    import mips_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  word_t             wdata,
    output word_t             rdata
);

    // Contents start at zero and are never cleared by reset
    word_t mem [MEM_WORDS] = '{default: '0};

    // Store the write data on the rising edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read port, forced to zero when no load is requested
    always_comb begin
        rdata = '0;
        if (re) begin
            rdata = mem[addr];
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: data-memory access, branch resolution and the
// MEM/WB pipeline register. One instruction per cycle, no stalls.
module mem_stage
    import mips_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  wb_ctl_t     wb_ctlout,
    input  m_ctl_t      m_ctlout,
    input  word_t       add_result,
    input  logic        zero,
    input  word_t       alu_result,
    input  word_t       rdata2out,
    input  logic [4:0]  five_bit_muxout,
    output logic        pcsrc,
    output word_t       branch_target,
    output wb_ctl_t     memwb_wb,
    output word_t       memwb_read_data,
    output word_t       memwb_alu_result,
    output logic [4:0]  memwb_write_reg
);

    logic [ADDR_W-1:0] word_index;
    logic              mem_we;
    logic              mem_re;
    word_t             mem_rdata;

    // Byte-offset bits and bits above the memory size are dropped, so
    // addresses wrap and misaligned addresses silently round down.
    assign word_index = alu_result[ADDR_W+1:2];

    // A store presented together with reset is discarded
    assign mem_we = m_ctlout[M_MEMWRITE] & ~rst;
    assign mem_re = m_ctlout[M_MEMREAD];

    // Branch decision goes straight back to the PC mux, unregistered
    assign pcsrc         = m_ctlout[M_BRANCH] & zero & ~rst;
    assign branch_target = add_result;

    data_memory #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_data_memory (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (word_index),
        .wdata (rdata2out),
        .rdata (mem_rdata)
    );

    // MEM/WB pipeline register, cleared while reset is held
    always_ff @(posedge clk) begin
        if (rst) begin
            memwb_wb         <= '0;
            memwb_read_data  <= '0;
            memwb_alu_result <= '0;
            memwb_write_reg  <= '0;
        end else begin
            memwb_wb         <= wb_ctlout;
            memwb_read_data  <= mem_rdata;
            memwb_alu_result <= alu_result;
            memwb_write_reg  <= five_bit_muxout;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases followed by random traffic, with an
// expected-result queue filled by the driver and drained by a monitor.
module tb_mem_stage;

  localparam int MEM_WORDS = 256;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wb_ctlout = '0;
  logic [2:0]  m_ctlout = '0;
  logic [31:0] add_result = '0;
  logic        zero = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] rdata2out = '0;
  logic [4:0]  five_bit_muxout = '0;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic [1:0]  memwb_wb;
  logic [31:0] memwb_read_data;
  logic [31:0] memwb_alu_result;
  logic [4:0]  memwb_write_reg;

  always #5 clk = ~clk;

  mem_stage #(.MEM_WORDS(MEM_WORDS), .ADDR_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_ctlout        (wb_ctlout),
    .m_ctlout         (m_ctlout),
    .add_result       (add_result),
    .zero             (zero),
    .alu_result       (alu_result),
    .rdata2out        (rdata2out),
    .five_bit_muxout  (five_bit_muxout),
    .pcsrc            (pcsrc),
    .branch_target    (branch_target),
    .memwb_wb         (memwb_wb),
    .memwb_read_data  (memwb_read_data),
    .memwb_alu_result (memwb_alu_result),
    .memwb_write_reg  (memwb_write_reg)
  );

  // ---------------- reference model ----------------
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] model_mem [MEM_WORDS];
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one instruction on the falling edge, checks the combinational
  // branch outputs, and queues the MEM/WB contents expected after the edge.
  task automatic drive(input logic r, input logic [1:0] wb, input logic [2:0] m,
                       input logic [31:0] add, input logic z, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] wr);
    exp_t e;
    int unsigned idx;
    @(negedge clk);
    rst = r; wb_ctlout = wb; m_ctlout = m; add_result = add; zero = z;
    alu_result = alu; rdata2out = wd; five_bit_muxout = wr;
    #1;
    check("pcsrc", {31'd0, pcsrc}, {31'd0, (m[2] && z && !r)});
    check("branch_target", branch_target, add);
    idx = (alu / 4) % MEM_WORDS;
    if (r) begin
      e = '0;
    end else begin
      e.wb  = wb;
      e.rd  = m[1] ? model_mem[idx] : 32'd0;
      e.alu = alu;
      e.wr  = wr;
      if (m[0]) model_mem[idx] = wd;
    end
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [31:0] alu, input logic [4:0] wr);
    drive(1'b0, 2'b11, 3'b010, 32'h0, 1'b0, alu, 32'h0, wr);
  endtask

  task automatic store(input logic [31:0] alu, input logic [31:0] wd);
    drive(1'b0, 2'b00, 3'b001, 32'h0, 1'b0, alu, wd, 5'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("memwb_wb", {30'd0, memwb_wb}, {30'd0, e.wb});
        check("memwb_read_data", memwb_read_data, e.rd);
        check("memwb_alu_result", memwb_alu_result, e.alu);
        check("memwb_write_reg", {27'd0, memwb_write_reg}, {27'd0, e.wr});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = '0;

    // Reset with every input nonzero, store enabled: nothing may land
    drive(1'b1, 2'b11, 3'b111, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 5'd31);
    drive(1'b1, 2'b11, 3'b111, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 5'd31);
    load(32'h0, 5'd1);                               // word 0 still zero

    // Store then load
    store(32'h10, 32'hDEAD_BEEF);
    load(32'h10, 5'd9);

    // Same-cycle read/write at index 4
    store(32'h10, 32'h1111_1111);
    drive(1'b0, 2'b10, 3'b011, 32'h0, 1'b0, 32'h10, 32'h2222_2222, 5'd4);
    load(32'h10, 5'd5);

    // Wrap and ignored low bits: 0x403 lands in word 0
    store(32'h0000_0403, 32'hA5A5_A5A5);
    load(32'h0, 5'd6);

    // Branch outcomes
    drive(1'b0, 2'b00, 3'b100, 32'h0040_0020, 1'b1, 32'h0, 32'h0, 5'd0);
    drive(1'b0, 2'b00, 3'b100, 32'h0040_0020, 1'b0, 32'h0, 32'h0, 5'd0);
    drive(1'b1, 2'b00, 3'b100, 32'h0040_0020, 1'b1, 32'h0, 32'h0, 5'd0);

    // Store lost to reset at index 7
    drive(1'b1, 2'b00, 3'b001, 32'h0, 1'b0, 32'h1C, 32'h5, 5'd0);
    load(32'h1C, 5'd7);

    // Random traffic over a small index window to get frequent hits
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 3) == 0 ? $urandom() : 32'd0} & 32'hFFFF_FC00;
      a = a | {22'd0, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      drive($urandom_range(0, 29) == 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            $urandom(), 1'($urandom_range(0, 1)), a, $urandom(), 5'($urandom_range(0, 31)));
    end

    // Drain: everything queued must have been seen
    drive(1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
